// File: rtl/font_rom.sv
// Character glyph ROM: 256 x 32-bit constant table of 4x8 bitmaps,
// one registered lookup per cycle with a selectable pixel output.
module font_rom (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ch_code,
  input  logic [1:0] px_col,
  input  logic [2:0] px_row,
  output logic [31:0] char_gfx,
  output logic        px_on,
  output logic        gfx_valid
);

  localparam int FONT_W = 4;
  localparam int FONT_H = 8;
  localparam int GW     = FONT_W * FONT_H;

  logic [GW-1:0] gfx_d, gfx_q;
  logic          px_d, px_q;
  logic          vld_q;
  logic [4:0]    px_idx;

  // Row r is nibble r from the top, column 0 is the nibble MSB
  always_comb begin
    gfx_d = '0;
    case (ch_code)
      8'h21: gfx_d = 32'h44404000;
      8'h22: gfx_d = 32'hAA000000;
      8'h23: gfx_d = 32'hAEAEA000;
      8'h24: gfx_d = 32'h6C46C000;
      8'h25: gfx_d = 32'hA248A000;
      8'h26: gfx_d = 32'h4A4A6000;
      8'h27: gfx_d = 32'h44000000;
      8'h28: gfx_d = 32'h24442000;
      8'h29: gfx_d = 32'h84448000;
      8'h2A: gfx_d = 32'h0A4A0000;
      8'h2B: gfx_d = 32'h04E40000;
      8'h2C: gfx_d = 32'h00048000;
      8'h2D: gfx_d = 32'h00E00000;
      8'h2E: gfx_d = 32'h00004000;
      8'h2F: gfx_d = 32'h22488000;
      8'h30: gfx_d = 32'hEAAAE000;
      8'h31: gfx_d = 32'h4C44E000;
      8'h32: gfx_d = 32'hE2E8E000;
      8'h33: gfx_d = 32'hE2E2E000;
      8'h34: gfx_d = 32'hAAE22000;
      8'h35: gfx_d = 32'hE8E2E000;
      8'h36: gfx_d = 32'hE8EAE000;
      8'h37: gfx_d = 32'hE2222000;
      8'h38: gfx_d = 32'hEAEAE000;
      8'h39: gfx_d = 32'hEAE2E000;
      8'h3A: gfx_d = 32'h04040000;
      8'h3B: gfx_d = 32'h04048000;
      8'h3C: gfx_d = 32'h24842000;
      8'h3D: gfx_d = 32'h0E0E0000;
      8'h3E: gfx_d = 32'h84248000;
      8'h3F: gfx_d = 32'hE2604000;
      8'h40: gfx_d = 32'h4AE86000;
      8'h41: gfx_d = 32'h4AEAA000;
      8'h42: gfx_d = 32'hCACAC000;
      8'h43: gfx_d = 32'h68886000;
      8'h44: gfx_d = 32'hCAAAC000;
      8'h45: gfx_d = 32'hE8E8E000;
      8'h46: gfx_d = 32'hE8E88000;
      8'h47: gfx_d = 32'h68AA6000;
      8'h48: gfx_d = 32'hAAEAA000;
      8'h49: gfx_d = 32'hE444E000;
      8'h4A: gfx_d = 32'h222A4000;
      8'h4B: gfx_d = 32'hAACAA000;
      8'h4C: gfx_d = 32'h8888E000;
      8'h4D: gfx_d = 32'hAEEAA000;
      8'h4E: gfx_d = 32'hCAAAA000;
      8'h4F: gfx_d = 32'h4AAA4000;
      8'h50: gfx_d = 32'hCAC88000;
      8'h51: gfx_d = 32'h4AAE6000;
      8'h52: gfx_d = 32'hCACAA000;
      8'h53: gfx_d = 32'h6842C000;
      8'h54: gfx_d = 32'hE4444000;
      8'h55: gfx_d = 32'hAAAAE000;
      8'h56: gfx_d = 32'hAAAA4000;
      8'h57: gfx_d = 32'hAAAEA000;
      8'h58: gfx_d = 32'hAA4AA000;
      8'h59: gfx_d = 32'hAA444000;
      8'h5A: gfx_d = 32'hE248E000;
      8'h5B: gfx_d = 32'h64446000;
      8'h5C: gfx_d = 32'h88422000;
      8'h5D: gfx_d = 32'hC444C000;
      8'h5E: gfx_d = 32'h4A000000;
      8'h5F: gfx_d = 32'h0000E000;
      8'h60: gfx_d = 32'h84000000;
      8'h61: gfx_d = 32'h0C6AE000;
      8'h62: gfx_d = 32'h88CAC000;
      8'h63: gfx_d = 32'h06886000;
      8'h64: gfx_d = 32'h226A6000;
      8'h65: gfx_d = 32'h04EC6000;
      8'h66: gfx_d = 32'h24E44000;
      8'h67: gfx_d = 32'h06A62C00;
      8'h68: gfx_d = 32'h88CAA000;
      8'h69: gfx_d = 32'h40444000;
      8'h6A: gfx_d = 32'h20222C00;
      8'h6B: gfx_d = 32'h8ACAA000;
      8'h6C: gfx_d = 32'hC444E000;
      8'h6D: gfx_d = 32'h0EEEA000;
      8'h6E: gfx_d = 32'h0CAAA000;
      8'h6F: gfx_d = 32'h04AA4000;
      8'h70: gfx_d = 32'h0CAC8800;
      8'h71: gfx_d = 32'h06A62200;
      8'h72: gfx_d = 32'h06888000;
      8'h73: gfx_d = 32'h06C6C000;
      8'h74: gfx_d = 32'h4E442000;
      8'h75: gfx_d = 32'h0AAA6000;
      8'h76: gfx_d = 32'h0AAA4000;
      8'h77: gfx_d = 32'h0AEEE000;
      8'h78: gfx_d = 32'h0A44A000;
      8'h79: gfx_d = 32'h0AA62C00;
      8'h7A: gfx_d = 32'h0E24E000;
      8'h7B: gfx_d = 32'h64C46000;
      8'h7C: gfx_d = 32'h44444000;
      8'h7D: gfx_d = 32'hC464C000;
      8'h7E: gfx_d = 32'h06C00000;
      8'h7F: gfx_d = 32'hFFFFFFFF;
      default: gfx_d = '0;
    endcase
  end

  // 31 - (4*row + col) is the bitwise inverse of {row, col}
  assign px_idx = ~{px_row, px_col};
  assign px_d   = gfx_d[px_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gfx_q <= '0;
      px_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      gfx_q <= gfx_d;
      px_q  <= px_d;
      vld_q <= 1'b1;
    end
  end

  assign char_gfx  = gfx_q;
  assign px_on     = px_q;
  assign gfx_valid = vld_q;

endmodule

// File: tb/tb_font_rom.sv
// Self-checking bench for font_rom: directed scenarios plus random
// lookups checked against a rule-based glyph model.
module tb_font_rom;

  logic        clk;
  logic        rst;
  logic [7:0]  ch_code;
  logic [1:0]  px_col;
  logic [2:0]  px_row;
  logic [31:0] char_gfx;
  logic        px_on;
  logic        gfx_valid;

  int vecs;
  int errs;

  font_rom dut (
    .clk      (clk),
    .rst      (rst),
    .ch_code  (ch_code),
    .px_col   (px_col),
    .px_row   (px_row),
    .char_gfx (char_gfx),
    .px_on    (px_on),
    .gfx_valid(gfx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Glyphs whose exact bitmap is fixed; returns 0 for free-form glyphs
  function automatic bit known_glyph(input int c, output logic [31:0] g);
    g = 32'h0;
    if (c <= 32'h20 || c >= 32'h80) return 1'b1;
    case (c)
      32'h7F: g = 32'hFFFFFFFF;
      32'h48: g = 32'hAAEAA000;
      32'h2D: g = 32'h00E00000;
      32'h30: g = 32'hEAAAE000;
      32'h57: g = 32'hAAAEA000;
      32'h65: g = 32'h04EC6000;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic logic pixel_of(input logic [31:0] g, input int r, input int c);
    return g[31 - (4 * r + c)];
  endfunction

  function automatic bit has_descender(input int c);
    return c == "g" || c == "j" || c == "p" || c == "q" || c == "y";
  endfunction

  // Drive on the falling edge, check 1 time unit after the next rising edge
  task automatic apply(input logic [7:0] c, input int r, input int col);
    @(negedge clk);
    ch_code = c;
    px_row  = 3'(r);
    px_col  = 2'(col);
    @(posedge clk);
    #1;
  endtask

  task automatic check_printable(input int c, input string tag);
    logic [31:0] m;
    vecs++;
    if ((char_gfx & 32'h11111111) !== 32'h0 || char_gfx[3:0] !== 4'h0) begin
      errs++;
      $display("FAIL %s code=%02h col3/row7 got=%08h want those bits 0", tag, c, char_gfx);
    end
    m = has_descender(c) ? 32'h0 : 32'h00000FF0;
    vecs++;
    if ((char_gfx & m) !== 32'h0 || char_gfx === 32'h0) begin
      errs++;
      $display("FAIL %s code=%02h rows5-6/blank got=%08h", tag, c, char_gfx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ch_code = 8'h48;
    px_row = 3'd2;
    px_col = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      vecs++;
      if (char_gfx !== 32'h0 || px_on !== 1'b0 || gfx_valid !== 1'b0) begin
        errs++;
        $display("FAIL reset gfx=%08h px=%b vld=%b want 0/0/0", char_gfx, px_on, gfx_valid);
      end
    end
  endtask

  task automatic test_first_lookup();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vecs++;
    if (char_gfx !== 32'hAAEAA000 || px_on !== 1'b1 || gfx_valid !== 1'b1) begin
      errs++;
      $display("FAIL first gfx=%08h px=%b vld=%b want AAEAA000/1/1", char_gfx, px_on, gfx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  codes[4] = '{8'h20, 8'h7F, 8'h2D, 8'h30};
    logic [31:0] want[4]  = '{32'h0, 32'hFFFFFFFF, 32'h00E00000, 32'hEAAAE000};
    for (int i = 0; i < 4; i++) begin
      apply(codes[i], 1, 1);
      vecs++;
      if (char_gfx !== want[i] || px_on !== pixel_of(want[i], 1, 1)) begin
        errs++;
        $display("FAIL b2b[%0d] gfx=%08h px=%b want %08h", i, char_gfx, px_on, want[i]);
      end
    end
  endtask

  task automatic test_pixel_sweep();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 4; c++) begin
          apply(k == 0 ? 8'h7F : 8'h00, r, c);
          vecs++;
          if (px_on !== (k == 0)) begin
            errs++;
            $display("FAIL pxsweep k=%0d r=%0d c=%0d got=%b want=%b", k, r, c, px_on, k == 0);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    apply(8'h7F, 0, 0);
    vecs++;
    if (char_gfx !== 32'hFFFFFFFF) begin
      errs++;
      $display("FAIL arst_pre gfx=%08h want FFFFFFFF", char_gfx);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if (char_gfx !== 32'h0 || px_on !== 1'b0 || gfx_valid !== 1'b0) begin
      errs++;
      $display("FAIL arst gfx=%08h px=%b vld=%b want 0/0/0", char_gfx, px_on, gfx_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    ch_code = 8'h57;
    px_row = 3'd3;
    px_col = 2'd2;
    @(posedge clk);
    #1;
    vecs++;
    if (char_gfx !== 32'hAAAEA000 || px_on !== 1'b1 || gfx_valid !== 1'b1) begin
      errs++;
      $display("FAIL arst_rel gfx=%08h px=%b vld=%b want AAAEA000/1/1", char_gfx, px_on, gfx_valid);
    end
  endtask

  task automatic test_code_sweep();
    for (int c = 0; c < 256; c++) begin
      apply(8'(c), 0, 0);
      if (c < 32'h21 || c >= 32'h80) begin
        vecs++;
        if (char_gfx !== 32'h0) begin
          errs++;
          $display("FAIL blank code=%02h got=%08h want 00000000", c, char_gfx);
        end
      end else if (c != 32'h7F) begin
        check_printable(c, "sweep");
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] g;
    int c, r, col;
    for (int i = 0; i < 400; i++) begin
      c   = int'($urandom_range(0, 255));
      if (i % 3 == 0) c = 32'h20 + int'($urandom_range(0, 96));
      r   = int'($urandom_range(0, 7));
      col = int'($urandom_range(0, 3));
      apply(8'(c), r, col);
      vecs++;
      if (gfx_valid !== 1'b1) begin
        errs++;
        $display("FAIL rnd_vld code=%02h got=%b want 1", c, gfx_valid);
      end
      if (known_glyph(c, g)) begin
        vecs++;
        if (char_gfx !== g || px_on !== pixel_of(g, r, col)) begin
          errs++;
          $display("FAIL rnd code=%02h r=%0d c=%0d gfx=%08h px=%b want %08h/%b",
                   c, r, col, char_gfx, px_on, g, pixel_of(g, r, col));
        end
      end else begin
        check_printable(c, "rnd");
        vecs++;
        if (px_on === 1'b1 && (col == 3 || r == 7)) begin
          errs++;
          $display("FAIL rnd_px code=%02h r=%0d c=%0d got=1 want 0", c, r, col);
        end
      end
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_first_lookup();
    test_back_to_back();
    test_pixel_sweep();
    test_async_reset();
    test_code_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/font_rom.md
FONT_ROM -- requirements
Module: font_rom

Interface
REQ-001 The block SHALL have parameter FONT_W, default 4, giving the glyph width in pixels; the value is fixed and not overridable.
REQ-002 The block SHALL have parameter FONT_H, default 8, giving the glyph height in pixels; the value is fixed and not overridable.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port ch_code, input, 8 bits: character code (ASCII) to look up.
REQ-006 Port px_col, input, 2 bits: pixel column within the glyph, 0 = leftmost.
REQ-007 Port px_row, input, 3 bits: pixel row within the glyph, 0 = top.
REQ-008 Port char_gfx, output, 32 bits: registered glyph bitmap for ch_code.
REQ-009 Port px_on, output, 1 bit: registered value of the selected glyph pixel.
REQ-010 Port gfx_valid, output, 1 bit: high when char_gfx and px_on hold a looked-up result.

Function
REQ-011 The block SHALL contain a 256-entry x 32-bit constant glyph table indexed by ch_code; the table has no write port.
REQ-012 Bitmap layout SHALL be: row r occupies char_gfx[31-4r : 28-4r]; within each nibble the MSB is column 0 (leftmost); bit value 1 = pixel lit.
REQ-013 Each rising clk edge SHALL register char_gfx <= table[ch_code]: latency exactly 1 cycle, throughput 1 lookup per cycle.
REQ-014 Each rising clk edge SHALL register px_on <= table[ch_code][31 - (4*px_row + px_col)], sampled on the same edge as char_gfx.
REQ-015 gfx_valid SHALL be 0 while rst is high, and SHALL become 1 on the first rising clk edge after rst deasserts and stay 1.
REQ-016 Codes 0x00-0x1F, 0x20 (space) and 0x80-0xFF SHALL map to 0x00000000.
REQ-017 Code 0x7F SHALL map to 0xFFFFFFFF (full block).
REQ-018 Codes 0x21-0x7E SHALL hold legible 3x5 glyphs in columns 0-2 and rows 0-4; column 3 and rows 5-7 SHALL be 0, except that descenders of g, j, p, q, y may use rows 5-6.
REQ-019 Fixed glyphs: 'H' (0x48) = 0xAAEAA000; '-' (0x2D) = 0x00E00000; '0' (0x30) = 0xEAAAE000; 'W' (0x57) = 0xAAAEA000; 'e' (0x65) = 0x04EC6000.
REQ-020 ch_code values with X/Z bits SHALL NOT be decoded; the output for them is don't-care, with no latch inferred.
REQ-021 The lookup SHALL be a pure function of ch_code; back-to-back different codes SHALL yield back-to-back results with no bubbles.

Reset
REQ-022 While rst is high, char_gfx SHALL be 0x00000000, px_on 0 and gfx_valid 0, independent of clk.
REQ-023 Asserting rst mid-stream SHALL clear all outputs immediately and asynchronously, with no partial result retained.
REQ-024 Deasserting rst SHALL take effect on the next rising clk edge, which performs a normal lookup.

Verification
REQ-025 Hold rst=1 with ch_code=0x48 and toggle clk -> char_gfx=0, px_on=0, gfx_valid=0.
REQ-026 Release rst, apply ch_code=0x48, px_row=2, px_col=1, then one clk edge -> char_gfx=0xAAEAA000, px_on=1, gfx_valid=1.
REQ-027 Apply codes 0x20, 0x7F, 0x2D, 0x30 on consecutive cycles -> outputs 0x0, 0xFFFFFFFF, 0x00E00000, 0xEAAAE000, each one cycle after its input.
REQ-028 Apply ch_code=0x7F and sweep all 32 (px_row, px_col) pairs -> px_on=1 for all; ch_code=0x00 -> px_on=0 for all.
REQ-029 Assert rst asynchronously between clk edges while char_gfx=0xFFFFFFFF -> char_gfx=0 before the next clk edge.
REQ-030 Sweep codes 0x80-0xFF and 0x00-0x1F -> char_gfx=0 for every code; codes 0x21-0x7E -> column 3 and row 7 bits are 0.
